// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// address-alignment mask and the illegal-access check.
package dmem_responder_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   // Position of the error flag in the latched request status
   localparam int unsigned DmemErrBit = 0;
   // Position of the store flag in the latched request status
   localparam int unsigned DmemWeBit  = 1;

   // Low address bits that must be zero for a word access
   localparam logic [31:0] AddrAlignMask = 32'h0000_0003;

   // Largest wait-state count the 4-bit counter can represent
   localparam int unsigned MaxWaitCycles = 15;

   // Misaligned, or word index beyond the RAM (also catches any high address bits)
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
      return ((addr & AddrAlignMask) != 32'd0) || ({2'b00, addr[31:2]} >= depth_words);
   endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port synchronous data RAM with byte-lane write enables and a
// registered read port. Contents are never reset.
module dmem_responder_ram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AddrW       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AddrW-1:0] addr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       be,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Lane-masked writes; read register only updates on loads so it holds through a response
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) begin
                  mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time over a valid/ready
// request channel, waits WAIT_CYCLES, performs the RAM access on entry to the
// response state and holds the response until the initiator takes it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        sync_rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AddrW    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES > MaxWaitCycles) begin : g_bad_wait
      $error("WAIT_CYCLES exceeds the wait counter range");
   end

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [1:0]         stat_q, stat_d;
   logic [AddrW-1:0]   idx_q, idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         be_q, be_d;

   logic               accept;
   logic               req_err;
   logic               mem_access;
   logic               ram_en;
   logic               ram_we;
   logic [AddrW-1:0]   ram_addr;
   logic [31:0]        ram_wdata;
   logic [3:0]         ram_be;
   logic [31:0]        ram_rdata;

   // Handshake outputs are forced low while reset is held
   assign req_ready = sync_rst_n && (state_q == StIdle);
   assign rsp_valid = sync_rst_n && (state_q == StResp);
   assign accept    = req_valid && req_ready;
   assign req_err   = addr_err(req_addr, DEPTH_WORDS);

   assign rsp_err   = rsp_valid && stat_q[DmemErrBit];
   assign rsp_rdata = (rsp_valid && !stat_q[DmemWeBit] && !stat_q[DmemErrBit]) ?
                      ram_rdata : 32'd0;

   // A pending access is dropped if reset arrives before it is performed
   assign ram_en = mem_access && sync_rst_n;

   // Next-state, request capture and RAM access steering
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stat_d     = stat_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      mem_access = 1'b0;
      ram_we     = stat_q[DmemWeBit];
      ram_addr   = idx_q;
      ram_wdata  = wdata_q;
      ram_be     = be_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               stat_d[DmemErrBit] = req_err;
               stat_d[DmemWeBit]  = req_we;
               idx_d              = req_addr[AddrW+1:2];
               wdata_d            = req_wdata;
               be_d               = req_be;
               cnt_d              = WaitLoad;
               if (WAIT_CYCLES > 0) begin
                  state_d = StWait;
               end else begin
                  // No wait states: access straight from the live request
                  state_d    = StResp;
                  mem_access = !req_err;
                  ram_we     = req_we;
                  ram_addr   = req_addr[AddrW+1:2];
                  ram_wdata  = req_wdata;
                  ram_be     = req_be;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d    = StResp;
               mem_access = !stat_q[DmemErrBit];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and latched-request registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         stat_q  <= 2'b00;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stat_q  <= stat_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   dmem_responder_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AddrW       (AddrW)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .be    (ram_be),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic against a word-array reference model. A second instance built
// with zero wait states covers the back-to-back case.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WAITS = 2;

   logic        clk = 1'b0;
   logic        sync_rst_n;
   int          cyc = 0;
   int          n_total = 0;
   int          n_bad = 0;

   // Instance with wait states
   logic        req_valid, req_we, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   // Zero-wait instance
   logic        z_req_valid, z_req_we;
   logic [31:0] z_req_addr, z_req_wdata;
   logic [3:0]  z_req_be;
   logic        z_req_ready, z_rsp_valid, z_rsp_err;
   logic [31:0] z_rsp_rdata;

   logic [31:0] mm  [DEPTH];
   logic [31:0] mm0 [DEPTH];

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES (WAITS)
   ) dut (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES (0)
   ) dut0 (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .req_valid  (z_req_valid),
      .req_ready  (z_req_ready),
      .req_we     (z_req_we),
      .req_addr   (z_req_addr),
      .req_wdata  (z_req_wdata),
      .req_be     (z_req_be),
      .rsp_valid  (z_rsp_valid),
      .rsp_ready  (1'b1),
      .rsp_rdata  (z_rsp_rdata),
      .rsp_err    (z_rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a);
      return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
   endfunction

   // One transaction on the wait-state instance, holding the response for 'hold' cycles
   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold);
      logic [31:0] exp_d;
      logic        exp_e;
      int          lat;
      int          idx;
      exp_e = model_err(addr);
      exp_d = 32'd0;
      if (!exp_e) begin
         idx = int'(addr / 32'd4);
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mm[idx][8*i +: 8] = wdata[8*i +: 8];
            end
         end else begin
            exp_d = mm[idx];
         end
      end
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      lat = 0;
      while (!req_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_rdy"}, 32'(req_ready), 32'd1);
      @(negedge clk);
      // Scramble the request after acceptance; it must not matter
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_be = 4'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(WAITS + 1));
      check({tag, "_data"}, rsp_rdata, exp_d);
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
      check({tag, "_busy"}, 32'(req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         // A competing request during backpressure must be ignored
         req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd0;
         req_wdata = 32'hA5A5_A5A5; req_be = 4'hF;
         @(negedge clk);
         check({tag, "_hv"}, 32'(rsp_valid), 32'd1);
         check({tag, "_hd"}, rsp_rdata, exp_d);
         check({tag, "_he"}, 32'(rsp_err), 32'(exp_e));
         check({tag, "_hr"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_rel"}, 32'(req_ready), 32'd1);
      check({tag, "_done"}, 32'(rsp_valid), 32'd0);
   endtask

   // Start a transaction, then reset while it sits in the wait state
   task automatic reset_in_wait(input string tag, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      @(negedge clk);
      check({tag, "_rdy"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      sync_rst_n = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_in_rst"}, 32'(req_ready), 32'd0);
      check({tag, "_v_in_rst"}, 32'(rsp_valid), 32'd0);
      sync_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
         if (i == 0) check({tag, "_rdy_after"}, 32'(req_ready), 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, d, exp_d;
      logic        we, exp_e;
      logic [3:0]  be;
      int          kind, t, acc, prev_acc, w;

      sync_rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
      rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
      z_req_be = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_rdy", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      sync_rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rdy", 32'(req_ready), 32'd1);
      check("post_rst_rdy0", 32'(z_req_ready), 32'd1);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);

      // Give the first 16 words known contents
      for (int i = 0; i < 16; i++) txn("init", 1'b1, 32'(i * 4), $urandom, 4'hF, 0);

      txn("t1_st", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
      txn("t1_ld", 1'b0, 32'h10, 32'd0, 4'hF, 0);
      txn("t2_st", 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 0);
      txn("t2_ld", 1'b0, 32'h10, 32'd0, 4'hF, 0);
      check("t2_model", mm[4], 32'hDEAD_AAEF);
      txn("t3_mis", 1'b0, 32'h13, 32'd0, 4'hF, 0);
      txn("t3_oor", 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0);
      txn("t3_hi", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 0);
      txn("t3_ld0", 1'b0, 32'h0, 32'd0, 4'hF, 0);
      txn("t3_be0", 1'b1, 32'h8, 32'h1234_5678, 4'b0000, 0);
      txn("t3_ld8", 1'b0, 32'h8, 32'd0, 4'hF, 0);
      txn("t4_bp", 1'b0, 32'h10, 32'd0, 4'hF, 5);
      txn("t4_ld0", 1'b0, 32'h0, 32'd0, 4'hF, 0);

      reset_in_wait("t5_ld", 1'b0, 32'h10, 32'd0);
      txn("t5_ld_after", 1'b0, 32'h10, 32'd0, 4'hF, 0);
      reset_in_wait("t5_st", 1'b1, 32'h20, 32'h1111_1111);
      txn("t5_st_dropped", 1'b0, 32'h20, 32'd0, 4'hF, 0);

      // Random mix of legal, misaligned and out-of-range traffic with backpressure
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 9));
         w = int'($urandom_range(0, 15));
         if (kind == 0) a = 32'(w * 4) + 32'($urandom_range(1, 3));
         else if (kind == 1) a = 32'(($urandom_range(0, 3000) + DEPTH) * 4);
         else if (kind == 2) a = 32'h8000_0000 | 32'(w * 4);
         else a = 32'(w * 4);
         txn("rnd", 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
      end

      // Zero wait states: back-to-back, response ready tied high
      prev_acc = 0;
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         we = (k < 4) ? 1'b1 : 1'($urandom);
         w = (k < 4) ? k : int'($urandom_range(0, 3));
         a = (k == 9) ? 32'h2 : 32'(w * 4);
         d = $urandom;
         be = (k < 4) ? 4'hF : 4'($urandom);
         z_req_valid = 1'b1; z_req_we = we; z_req_addr = a; z_req_wdata = d; z_req_be = be;
         t = 0;
         while (!z_req_ready && t < 10) begin
            @(negedge clk);
            t++;
         end
         acc = cyc;
         exp_e = model_err(a);
         exp_d = 32'd0;
         if (!exp_e) begin
            if (we) begin
               for (int i = 0; i < 4; i++) begin
                  if (be[i]) mm0[w][8*i +: 8] = d[8*i +: 8];
               end
            end else begin
               exp_d = mm0[w];
            end
         end
         @(negedge clk);
         check("z_lat", 32'(z_rsp_valid), 32'd1);
         check("z_data", z_rsp_rdata, exp_d);
         check("z_err", 32'(z_rsp_err), 32'(exp_e));
         if (k > 0) check("z_spacing", 32'(acc - prev_acc), 32'd2);
         prev_acc = acc;
      end
      z_req_valid = 1'b0;
      @(negedge clk);
      check("z_idle", 32'(z_req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services load/store requests issued by the core's MEM stage over a valid/ready request channel and a valid/ready response channel. It owns a word-organised data RAM with byte-lane write enables and a configurable number of wait states, to model multi-cycle memory. It also flags illegal accesses. This block is the memory end of the core's data-memory interface; the core's MEM stage is the initiator.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the data RAM (power of two).
WAIT_CYCLES, 2, extra wait cycles between request acceptance and response (0 allowed, max 15).

Ports:
clk  in  1  core clock; all logic on rising edge
sync_rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  initiator presents a request
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, lane-aligned
req_be  in  4  byte enables; bit i covers wdata[8i+7:8i]
rsp_valid  out  1  response available
rsp_ready  in  1  initiator accepts the response
rsp_rdata  out  32  load data (0 for stores and errors)
rsp_err  out  1  access was misaligned or out of range

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (sync_rst_n).
- Reset: state=IDLE, req_ready=1 from the first cycle after release (0 while sync_rst_n=0), rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be. Go to WAIT if WAIT_CYCLES>0, else go to RESP. The counter loads WAIT_CYCLES-1.
  - WAIT: req_ready=0. Decrement the counter. When it reaches 0, go to RESP.
  - RESP: rsp_valid=1 and req_ready=0. Hold rsp_rdata and rsp_err stable until rsp_ready=1. On the handshake cycle, go to IDLE.
- Memory access is performed on the transition into RESP.
  - Load: rsp_rdata = RAM[word].
  - Store: write lanes where be[i]=1; rsp_rdata=0.
  - be=4'b0000 store is a legal no-op.
- Latency: request accepted in cycle N gives rsp_valid in cycle N+1+WAIT_CYCLES.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles. No pipelining, no outstanding requests beyond one.
- Word index = req_addr[31:2]. Error if req_addr[1:0]!=0, or if the index >= DEPTH_WORDS. This also covers any nonzero address bits above log2(DEPTH_WORDS)+1.
  - On error: rsp_err=1, rsp_rdata=0, no RAM write. The error still takes the full latency.
- req_valid while req_ready=0 is ignored. The initiator holds the request.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-transaction (WAIT or RESP) aborts it: no response is issued, and any pending store is dropped if not yet performed. A store performed on RESP entry stays committed.
- Request fields are sampled only at the accept edge. Later changes on req_* have no effect.

Decomposition:
- Shared header include/DmemResponderDefs.vh holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - DMEM_ERR bit position
  - the address-alignment mask
- Sub-module dmem_responder_ram: single-port synchronous RAM, DEPTH_WORDS x 32, with 4 byte-lane write enables and registered read data. The FSM/counter/error logic stays in the parent.

Test Plan:
1. WAIT_CYCLES=2. Store 0xDEADBEEF to 0x10 with be=4'b1111, then load 0x10 → rsp_valid exactly 3 cycles after each accept, load rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Partial store of 0x0000AA00 to 0x10 with be=4'b0010 after test 1, then load 0x10 → rsp_rdata=0xDEADAAEF.
3. Load at 0x13, and store 0xFFFFFFFF at 0x1000 with DEPTH_WORDS=1024 → both return rsp_err=1 and rsp_rdata=0. A following load of 0x0 returns its prior value unchanged.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a new req_valid is not accepted. Releasing rsp_ready gives req_ready=1 the next cycle.
5. Pull sync_rst_n low for 1 cycle during WAIT of a load → rsp_valid never rises for that load, req_ready=1 the cycle after release, and a new load of 0x10 returns the stored data.
6. Rebuild with WAIT_CYCLES=0 and issue back-to-back loads with rsp_ready tied to 1 → rsp_valid in cycle N+1, and a new accept every 2 cycles.
